// File: rtl/lcd_fb_arbiter.sv
// Framebuffer RAM arbiter: keeps an FWFT prefetch FIFO topped up for LCD scanout
// and hands every RAM cycle the scanout does not urgently need to CPU writes.
module lcd_fb_arbiter #(
  parameter int H_ACTIVE   = 480,
  parameter int V_ACTIVE   = 272,
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pix_req,
  output logic [23:0]       pix_data,
  output logic              underrun,
  input  logic              cpu_wr_valid,
  output logic              cpu_wr_ready,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  input  logic [23:0]       cpu_wr_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [23:0]       ram_wdata,
  input  logic [23:0]       ram_rdata
);

  localparam int DATA_W = 24;
  localparam int PIXELS = H_ACTIVE * V_ACTIVE;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;

  localparam logic [LVL_W-1:0]  DEPTH_L   = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]  HALF_L    = LVL_W'(FIFO_DEPTH / 2);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] rd_addr;
  logic              rd_vld_p1;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [LVL_W-1:0]  credits;

  logic urgent;
  logic rd_grant;
  logic wr_grant;
  logic have;
  logic avail;
  logic pop;
  logic push;
  logic fifo_rd;

  // Stage p0: arbitration, RAM request and FSM next state
  always_comb begin
    credits    = level + LVL_W'(rd_vld_p1);
    urgent     = (state == FETCH) && (credits < HALF_L);
    rd_grant   = 1'b0;
    wr_grant   = 1'b0;
    state_next = state;

    if (!rst) begin
      if (urgent) begin
        rd_grant = 1'b1;
      end else if (cpu_wr_valid) begin
        wr_grant = 1'b1;
      end else if ((state == FETCH) && (credits < DEPTH_L)) begin
        rd_grant = 1'b1;
      end
    end

    ram_en       = rd_grant | wr_grant;
    ram_we       = wr_grant;
    ram_addr     = wr_grant ? cpu_wr_addr : rd_addr;
    ram_wdata    = wr_grant ? cpu_wr_data : '0;
    cpu_wr_ready = !urgent && !rst;

    case (state)
      IDLE:    if (frame_start) state_next = FETCH;
      FETCH: begin
        if (frame_start) begin
          state_next = FETCH;
        end else if (rd_grant && (rd_addr == LAST_ADDR)) begin
          state_next = DONE;
        end
      end
      DONE:    if (frame_start) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Stage p1: read return; a word arriving while the FIFO is empty is shown directly
  always_comb begin
    have     = (level != '0);
    avail    = have || rd_vld_p1;
    pop      = pix_req && avail && !frame_start && !rst;
    fifo_rd  = pop && have;
    push     = rd_vld_p1 && !frame_start && !(pop && !have);
    underrun = !rst && pix_req && !avail;
    pix_data = '0;
    if (!rst) begin
      if (have) begin
        pix_data = fifo_mem[rd_ptr];
      end else if (rd_vld_p1) begin
        pix_data = ram_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr   <= '0;
      rd_vld_p1 <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
    end else begin
      // a read issued alongside frame_start belongs to the old frame
      rd_vld_p1 <= rd_grant && !frame_start;
      if (frame_start) begin
        rd_addr <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        level   <= '0;
      end else begin
        if (rd_grant) rd_addr <= rd_addr + 1'b1;
        if (push)     wr_ptr  <= wr_ptr + 1'b1;
        if (fifo_rd)  rd_ptr  <= rd_ptr + 1'b1;
        level <= level + LVL_W'(push) - LVL_W'(fifo_rd);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ram_rdata;
  end

endmodule

// File: tb/tb_lcd_fb_arbiter.sv
// Scoreboard bench for lcd_fb_arbiter: a queue-based reference model predicts every
// cycle's RAM request and pixel output; a monitor compares on the falling edge.
module tb_lcd_fb_arbiter;

  localparam int H   = 12;
  localparam int V   = 5;
  localparam int AW  = 9;
  localparam int D   = 16;
  localparam int PIX = H * V;
  localparam int MEM = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic          pix_req;
  logic [23:0]   pix_data;
  logic          underrun;
  logic          cpu_wr_valid;
  logic          cpu_wr_ready;
  logic [AW-1:0] cpu_wr_addr;
  logic [23:0]   cpu_wr_data;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [23:0]   ram_wdata;
  logic [23:0]   ram_rdata;

  always #5 clk = ~clk;

  lcd_fb_arbiter #(
    .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_req(pix_req),
    .pix_data(pix_data), .underrun(underrun),
    .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready),
    .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Framebuffer BRAM seen by the DUT: one-cycle read latency
  logic [23:0] fbmem [MEM];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) fbmem[ram_addr] <= ram_wdata;
      else        ram_rdata <= fbmem[ram_addr];
    end
  end

  function automatic logic [23:0] init_word(input int i);
    return 24'(i * 32'h00010307 + 32'h00123456);
  endfunction

  typedef struct {
    bit          en;
    bit          we;
    logic [AW-1:0] addr;
    logic [23:0] wdata;
    bit          ready;
    logic [23:0] pix;
    bit          und;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: the visible FIFO contents as a queue, a read becoming visible
  // one cycle after issue; scanout mode 0 idle, 1 fetching, 2 frame done.
  logic [23:0] m_mem [MEM];
  logic [23:0] m_vis[$];
  int m_mode = 0;
  int m_addr = 0;
  bit m_prev_rd = 0;
  int m_prev_addr = 0;

  task automatic cycle(input bit r, input bit fs, input bit pr, input bit wv,
                       input logic [AW-1:0] wa, input logic [23:0] wd);
    exp_t e;
    int cr;
    bit urg, rd, wr;
    @(posedge clk);
    #1;
    rst = r; frame_start = fs; pix_req = pr;
    cpu_wr_valid = wv; cpu_wr_addr = wa; cpu_wr_data = wd;
    e.en = 0; e.we = 0; e.addr = '0; e.wdata = '0; e.ready = 0; e.pix = '0; e.und = 0;
    if (r) begin
      exp_q.push_back(e);
      m_vis.delete();
      m_mode = 0; m_addr = 0; m_prev_rd = 0;
    end else begin
      cr  = m_vis.size();
      urg = (m_mode == 1) && (cr < D / 2);
      wr  = !urg && wv;
      rd  = (m_mode == 1) && (urg || (!wv && cr < D));
      e.en    = rd || wr;
      e.we    = wr;
      e.addr  = wr ? wa : AW'(m_addr);
      e.wdata = wd;
      e.ready = !urg;
      e.pix   = (m_vis.size() > 0) ? m_vis[0] : 24'h0;
      e.und   = pr && (m_vis.size() == 0);
      exp_q.push_back(e);
      m_prev_rd = rd;
      m_prev_addr = m_addr;
      if (fs) begin
        m_vis.delete();
        m_addr = 0;
        m_mode = 1;
      end else begin
        if (pr && m_vis.size() > 0) void'(m_vis.pop_front());
        if (rd) begin
          m_vis.push_back(m_mem[m_addr]);
          m_addr++;
          if (m_addr == PIX) m_mode = 2;
        end
      end
      if (wr) m_mem[wa] = wd;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ram_en", 32'(ram_en), 32'(e.en));
      check("ram_we", 32'(ram_we), 32'(e.we));
      check("cpu_wr_ready", 32'(cpu_wr_ready), 32'(e.ready));
      check("underrun", 32'(underrun), 32'(e.und));
      check("pix_data", 32'(pix_data), 32'(e.pix));
      if (e.en) check("ram_addr", 32'(ram_addr), 32'(e.addr));
      if (e.we) check("ram_wdata", 32'(ram_wdata), 32'(e.wdata));
    end
  end

  task automatic bound_check(input string name, input bit ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=timeout required=reached", name);
    end
  endtask

  initial begin
    int n;
    rst = 1; frame_start = 0; pix_req = 0;
    cpu_wr_valid = 0; cpu_wr_addr = '0; cpu_wr_data = '0;
    for (int i = 0; i < MEM; i++) begin
      fbmem[i] = init_word(i);
      m_mem[i] = init_word(i);
    end

    repeat (3) cycle(1, 0, 0, 0, '0, '0);
    repeat (3) cycle(0, 0, 0, 0, '0, '0);

    // fill after frame_start, no CPU, no scanout
    cycle(0, 1, 0, 0, '0, '0);
    repeat (24) cycle(0, 0, 0, 0, '0, '0);

    // FIFO full: CPU gets every cycle
    repeat (6) cycle(0, 0, 0, 1, 9'h100, 24'hABCDEF);

    // scanout drains while CPU keeps requesting
    repeat (8) cycle(0, 0, 1, 1, 9'h100, 24'hABCDEF);
    repeat (10) cycle(0, 0, 0, 0, '0, '0);

    // pop right after frame_start underruns; word 0 follows
    cycle(0, 1, 0, 0, '0, '0);
    cycle(0, 0, 1, 0, '0, '0);
    repeat (2) cycle(0, 0, 0, 0, '0, '0);
    cycle(0, 0, 1, 0, '0, '0);

    // restart the frame right after the read of address 37
    n = 0;
    while (!(m_prev_rd && m_prev_addr == 37) && n < 200) begin
      cycle(0, 0, 1, 0, '0, '0);
      n++;
    end
    bound_check("reach_addr37", n < 200);
    cycle(0, 1, 0, 0, '0, '0);
    repeat (4) cycle(0, 0, 0, 0, '0, '0);
    repeat (3) cycle(0, 0, 1, 0, '0, '0);

    // scan out the whole frame, then CPU-only time in DONE, then restart
    n = 0;
    while (m_mode != 2 && n < 300) begin
      cycle(0, 0, 1, 0, '0, '0);
      n++;
    end
    bound_check("reach_done", n < 300);
    for (int i = 0; i < 6; i++) cycle(0, 0, i % 2, 1, AW'(i), 24'(32'h00C0FFEE + i));
    repeat (4) cycle(0, 0, 1, 0, '0, '0);
    cycle(0, 1, 0, 0, '0, '0);
    repeat (12) cycle(0, 0, 0, 0, '0, '0);

    // reset mid-frame, then resume
    repeat (5) cycle(0, 0, 1, 0, '0, '0);
    cycle(1, 0, 1, 1, 9'h003, 24'h111111);
    repeat (2) cycle(0, 0, 1, 0, '0, '0);
    cycle(0, 1, 0, 0, '0, '0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 599) == 0), ($urandom_range(0, 149) == 0),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 4),
            AW'($urandom_range(0, MEM - 1)), 24'($urandom));
    end

    cycle(0, 0, 0, 0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    #1;
    bound_check("scoreboard_drained", exp_q.size() == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
